gray_counter: RTL and testbench
===============================

Name: gray_counter

Overview:
- Parametrised registered binary/Gray up/down counter with synchronous load.
- Gray output comes straight from a flop and changes exactly one bit per step, so it is safe to synchronise across clock domains.
- Pointer source for the async FIFO and for multi-bit status crossing; it supersedes the standalone combinational bin/Gray converters.

Parameters:
- WIDTH, 8, counter width in bits (>=2); counts 0 .. 2^WIDTH-1.
- RST_VAL, 0, binary value loaded on reset (WIDTH bits).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  step enable
- up  input  1  direction: 1 = increment, 0 = decrement; sampled only when en=1
- load  input  1  synchronous load strobe
- load_bin  input  WIDTH  binary value to load
- bin_out  output  WIDTH  registered binary count
- gray_out  output  WIDTH  registered Gray count, equal to bin2gray(bin_out)
- gray_next  output  WIDTH  combinational Gray value the counter will take on the next edge
- wrap  output  1  registered one-cycle pulse on wrap-around

Behaviour:
- Reset (rst_n=0, asynchronous):
  - bin_out=RST_VAL
  - gray_out=bin2gray(RST_VAL)
  - wrap=0
  - Reset deasserting mid-operation resumes from RST_VAL; no partial step.
- State: bin_q and gray_q are separate flops; gray_out is never decoded combinationally from bin_q.
- Per rising edge, in priority order:
  - load=1: bin_q<=load_bin, gray_q<=bin2gray(load_bin), wrap<=0. en and up are ignored.
  - else en=1, up=1: bin_q<=bin_q+1 modulo 2^WIDTH. wrap<=1 iff bin_q was all-ones.
  - else en=1, up=0: bin_q<=bin_q-1 modulo 2^WIDTH. wrap<=1 iff bin_q was zero.
  - else hold, wrap<=0.
- gray_q always receives bin2gray of the new bin_q value in the same edge.
- Latency: one cycle from en/load to bin_out/gray_out; wrap coincides with the post-wrap value.
- gray_next always equals the value gray_out takes at the next edge under the current inputs, load included. It may feed a same-clock full/empty comparator.
- Conversions:
  - bin2gray(b) = b ^ (b>>1)
  - gray2bin: bit i = XOR of gray bits WIDTH-1..i
- Invariant: a step with en=1 and load=0 changes exactly one bit of gray_out. A load may change any number of bits.
- Direction may change on any cycle. Consecutive up/down steps are legal and each obeys the single-bit rule.

Optional Feature:
- Macro: GRAY_CNT_SAT_EN
- Defined:
  - Counter saturates instead of wrapping: up at all-ones holds, down at zero holds.
  - wrap is replaced by a sat pulse with the same timing, asserted on the cycle an attempted step was blocked.
  - Port name stays wrap.
- Undefined: modulo wrap-around as described above.

Decomposition:
- Package gray_pkg holds:
  - functions bin2gray(logic [W-1:0]) and gray2bin(logic [W-1:0]), written as parametrised-width functions via a max width plus mask, or as a parameterised class static.
  - constant GRAY_DEFAULT_W = 8.
- No sub-module: the block is a single always_ff plus next-state logic. The bench reuses gray2bin from the package as its reference model.

Test Plan (WIDTH=8, RST_VAL=0):
- Reset, then en=1, up=1 for 9 cycles -> bin_out steps 01..09; gray_out steps 01,03,02,06,07,05,04,0C,0D; wrap stays 0.
- load=1, load_bin=FE, then en=1, up=1 for 2 cycles:
  - after the load: bin FE, gray 81, wrap 0
  - then bin FF, gray 80
  - then bin 00, gray 00, wrap=1 for one cycle only
- From 00 with en=1, up=0 -> bin FF, gray 80, wrap=1. Next down step -> bin FE, gray 81, wrap=0.
- load=1 and en=1 together with load_bin=3C -> bin 3C, gray 22; en is ignored. gray_next equals 22 in the cycle before the edge.
- Full 512-step sweep (256 up, then 256 down, random en gaps):
  - every gray_out change has a popcount of 1
  - gray2bin(gray_out)==bin_out each cycle
  - exactly 2 wrap pulses
- rst_n pulsed low mid-sweep at bin 57 -> outputs reach 00/00/0 immediately without waiting for a clock edge. Counting resumes from 00.
- With GRAY_CNT_SAT_EN: at FF, up step -> bin stays FF, wrap=1 for one cycle; at 00, down step -> bin stays 00, wrap=1.

Source files
------------

// File: rtl/gray_counter_pkg.sv
// Shared Gray-code helpers and types for the Gray counter family.
// Width-generic conversions work on a maximum-width word and are masked to the caller's width.
package gray_pkg;

  localparam int GRAY_DEFAULT_W = 8;
  localparam int GRAY_MAX_W     = 64;

  typedef logic [GRAY_MAX_W-1:0] gray_word_t;

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_LOAD,
    OP_UP,
    OP_DOWN
  } cnt_op_e;

  function automatic gray_word_t width_mask(input int w);
    gray_word_t m;
    if (w >= GRAY_MAX_W) m = '1;
    else                 m = (gray_word_t'(1) << w) - gray_word_t'(1);
    return m;
  endfunction

  function automatic gray_word_t bin2gray(input gray_word_t b, input int w);
    gray_word_t v;
    v = b & width_mask(w);
    return (v ^ (v >> 1));
  endfunction

  // Each binary bit is the running XOR of all Gray bits at or above it.
  function automatic gray_word_t gray2bin(input gray_word_t g, input int w);
    gray_word_t v;
    gray_word_t r;
    v = g & width_mask(w);
    r = '0;
    r[GRAY_MAX_W-1] = v[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      r[i] = r[i+1] ^ v[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/gray_counter.sv
// Registered binary/Gray up/down counter with synchronous load; Gray output is flop-driven.
// Optional feature: define GRAY_CNT_SAT_EN to saturate at the ends instead of wrapping.
module gray_counter
  import gray_pkg::*;
#(
  parameter int               WIDTH   = GRAY_DEFAULT_W,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic [WIDTH-1:0] gray_next,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] RST_GRAY = WIDTH'(bin2gray(GRAY_MAX_W'(RST_VAL), WIDTH));

  cnt_op_e          op;
  logic [WIDTH-1:0] bin_q,  bin_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             wrap_q, wrap_d;

  // Load beats a step; direction only matters when stepping.
  always_comb begin
    op = OP_HOLD;
    if (load)    op = OP_LOAD;
    else if (en) op = up ? OP_UP : OP_DOWN;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    bin_d  = bin_q;
    wrap_d = 1'b0;
    case (op)
      OP_LOAD: bin_d = load_bin;
      OP_UP: begin
`ifdef GRAY_CNT_SAT_EN
        if (bin_q == '1) wrap_d = 1'b1;
        else             bin_d  = bin_q + WIDTH'(1);
`else
        bin_d  = bin_q + WIDTH'(1);
        wrap_d = (bin_q == '1);
`endif
      end
      OP_DOWN: begin
`ifdef GRAY_CNT_SAT_EN
        if (bin_q == '0) wrap_d = 1'b1;
        else             bin_d  = bin_q - WIDTH'(1);
`else
        bin_d  = bin_q - WIDTH'(1);
        wrap_d = (bin_q == '0);
`endif
      end
      default: ;
    endcase
    gray_d = WIDTH'(bin2gray(GRAY_MAX_W'(bin_d), WIDTH));
  end

  // NOTE: state flops use non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= RST_VAL;
      gray_q <= RST_GRAY;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign bin_out   = bin_q;
  assign gray_out  = gray_q;
  assign gray_next = gray_d;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_gray_counter.sv
// Self-checking bench for gray_counter (WIDTH=8, RST_VAL=0) against an integer reference model.
// Honours GRAY_CNT_SAT_EN when the design is built with it.
module tb_gray_counter;
  import gray_pkg::*;

  localparam int W    = 8;
  localparam int MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en, up, load;
  logic [W-1:0] load_bin;
  logic [W-1:0] bin_out, gray_out, gray_next;
  logic         wrap;

  int checks = 0;
  int errors = 0;
  int model_bin = 0;
  int wrap_seen = 0;

  always #5 clk = ~clk;

  gray_counter #(.WIDTH(W), .RST_VAL('0)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_bin (load_bin),
    .bin_out  (bin_out),
    .gray_out (gray_out),
    .gray_next(gray_next),
    .wrap     (wrap)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_gray(input int b);
    return b ^ (b >> 1);
  endfunction

  // Reference behaviour from the counting rules, on plain integers.
  function automatic void model_next(input int b, input bit e, input bit u, input bit l,
                                     input int lb, output int nb, output bit w);
    nb = b;
    w  = 1'b0;
    if (l) begin
      nb = lb;
    end else if (e && u) begin
      if (b + 1 > MAXV) begin
        w = 1'b1;
`ifndef GRAY_CNT_SAT_EN
        nb = (b + 1) % (MAXV + 1);
`endif
      end else nb = b + 1;
    end else if (e) begin
      if (b - 1 < 0) begin
        w = 1'b1;
`ifndef GRAY_CNT_SAT_EN
        nb = (b + MAXV) % (MAXV + 1);
`endif
      end else nb = b - 1;
    end
  endfunction

  task automatic do_cycle(input bit e, input bit u, input bit l, input int lb);
    int           nb;
    bit           w;
    logic [W-1:0] prev_g;
    @(negedge clk);
    en = e; up = u; load = l; load_bin = W'(lb);
    model_next(model_bin, e, u, l, lb, nb, w);
    #1;
    check("gray_next", 32'(gray_next), 32'(ref_gray(nb)));
    prev_g = gray_out;
    @(posedge clk);
    #1;
    check("bin_out", 32'(bin_out), 32'(nb));
    check("gray_out", 32'(gray_out), 32'(ref_gray(nb)));
    check("wrap", 32'(wrap), 32'(w));
    check("gray2bin", 32'(W'(gray2bin(GRAY_MAX_W'(gray_out), W))), 32'(nb));
    if (!l) check("gray_1bit", 32'($countones(gray_out ^ prev_g)), (nb != model_bin) ? 32'd1 : 32'd0);
    if (wrap) wrap_seen++;
    model_bin = nb;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int exp_g [9] = '{'h01, 'h03, 'h02, 'h06, 'h07, 'h05, 'h04, 'h0C, 'h0D};
    int steps;

    rst_n = 1'b0; en = 1'b0; up = 1'b0; load = 1'b0; load_bin = '0;
    #3;
    check("rst_bin", 32'(bin_out), 32'h0);
    check("rst_gray", 32'(gray_out), 32'h0);
    check("rst_wrap", 32'(wrap), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_bin = 0;

    // Nine up steps from reset.
    for (int i = 0; i < 9; i++) begin
      do_cycle(1, 1, 0, 0);
      check("tp1_bin", 32'(bin_out), 32'(i + 1));
      check("tp1_gray", 32'(gray_out), 32'(exp_g[i]));
    end

    // Load FE then step up across the top.
    do_cycle(0, 0, 1, 'hFE);
    check("ld_fe_gray", 32'(gray_out), 32'h81);
    do_cycle(1, 1, 0, 0);
    check("up_ff_gray", 32'(gray_out), 32'h80);
    do_cycle(1, 1, 0, 0);
`ifdef GRAY_CNT_SAT_EN
    check("sat_top_bin", 32'(bin_out), 32'hFF);
`else
    check("wrap_top_bin", 32'(bin_out), 32'h00);
`endif
    check("top_wrap", 32'(wrap), 32'h1);
    do_cycle(0, 0, 0, 0);
    check("top_wrap_clr", 32'(wrap), 32'h0);

    // Down across zero.
    do_cycle(0, 0, 1, 'h00);
    do_cycle(1, 0, 0, 0);
`ifdef GRAY_CNT_SAT_EN
    check("sat_bot_bin", 32'(bin_out), 32'h00);
`else
    check("wrap_bot_gray", 32'(gray_out), 32'h80);
`endif
    check("bot_wrap", 32'(wrap), 32'h1);
    do_cycle(1, 0, 0, 0);
    check("bot_wrap_clr", 32'(wrap), 32'h0);

    // Load wins over a simultaneous step.
    do_cycle(1, 1, 1, 'h3C);
    check("ld_3c_bin", 32'(bin_out), 32'h3C);
    check("ld_3c_gray", 32'(gray_out), 32'h22);

    // Full sweep: 256 up steps then 256 down, with random idle gaps.
    do_cycle(0, 0, 1, 0);
    wrap_seen = 0;
    for (int dir = 1; dir >= 0; dir--) begin
      steps = 0;
      while (steps < 256) begin
        bit e;
        e = ($urandom_range(0, 3) != 0);
        do_cycle(e, bit'(dir), 0, 0);
        if (e) steps++;
      end
    end
    check("sweep_wraps", 32'(wrap_seen), 32'd2);

    // Asynchronous reset mid-count at 57.
    do_cycle(0, 0, 1, 'h50);
    steps = 0;
    while (model_bin != 'h57 && steps < 20) begin
      do_cycle(1, 1, 0, 0);
      steps++;
    end
    check("pre_rst_bin", 32'(bin_out), 32'h57);
    en = 1'b0; load = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_bin", 32'(bin_out), 32'h0);
    check("async_rst_gray", 32'(gray_out), 32'h0);
    check("async_rst_wrap", 32'(wrap), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_bin = 0;
    do_cycle(1, 1, 0, 0);
    check("resume_bin", 32'(bin_out), 32'h01);

    // Random mix of loads, steps and holds.
    for (int i = 0; i < 400; i++) begin
      bit l, e, u;
      l = ($urandom_range(0, 7) == 0);
      e = ($urandom_range(0, 3) != 0);
      u = 1'($urandom_range(0, 1));
      do_cycle(e, u, l, int'($urandom_range(0, MAXV)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
